// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master (AR + R) between
// S_COUNT requesters, one outstanding burst at a time.
module axi4_rd_arbiter #(
  parameter int S_COUNT    = 2,
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*ID_WIDTH-1:0]    s_axi_arid,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [S_COUNT*8-1:0]           s_axi_arlen,
  input  logic [S_COUNT-1:0]             s_axi_arvalid,
  output logic [S_COUNT-1:0]             s_axi_arready,
  output logic [S_COUNT*ID_WIDTH-1:0]    s_axi_rid,
  output logic [S_COUNT*DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [S_COUNT*2-1:0]           s_axi_rresp,
  output logic [S_COUNT-1:0]             s_axi_rlast,
  output logic [S_COUNT-1:0]             s_axi_rvalid,
  input  logic [S_COUNT-1:0]             s_axi_rready,
  output logic [ID_WIDTH-1:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  input  logic [ID_WIDTH-1:0]            m_axi_rid,
  input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp,
  input  logic                           m_axi_rlast,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready
);

  localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           g_q, g_d;
  logic [GW-1:0]           lg_q, lg_d;
  logic [ID_WIDTH-1:0]     arid_q, arid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic                    arvalid_q, arvalid_d;

  logic                    sel_vld;
  logic [GW-1:0]           sel;
  int                      idx;

  logic [S_COUNT-1:0]      arready_c;
  logic [S_COUNT-1:0]      rvalid_c;
  logic                    rready_c;

  // Scan starts just after the last served port, so it gets lowest priority
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int k = 1; k <= S_COUNT; k++) begin
      idx = (int'(lg_q) + k) % S_COUNT;
      if (!sel_vld && s_axi_arvalid[GW'(idx)]) begin
        sel_vld = 1'b1;
        sel     = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    lg_d      = lg_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    arready_c = '0;
    rvalid_c  = '0;
    rready_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          arready_c[sel] = 1'b1;
          arid_d    = s_axi_arid[int'(sel)*ID_WIDTH +: ID_WIDTH];
          araddr_d  = s_axi_araddr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          arlen_d   = s_axi_arlen[int'(sel)*8 +: 8];
          arvalid_d = 1'b1;
          g_d       = sel;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        rvalid_c[g_q] = m_axi_rvalid;
        rready_c      = s_axi_rready[g_q];
        if (m_axi_rvalid && rready_c && m_axi_rlast) begin
          lg_d    = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      arready_c = '0;
      rvalid_c  = '0;
      rready_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      lg_q      <= GW'(S_COUNT - 1);
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      lg_q      <= lg_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
    end
  end

  assign s_axi_arready = arready_c;
  assign s_axi_rvalid  = rvalid_c;
  assign m_axi_rready  = rready_c;
  assign s_axi_rid     = {S_COUNT{m_axi_rid}};
  assign s_axi_rdata   = {S_COUNT{m_axi_rdata}};
  assign s_axi_rresp   = {S_COUNT{m_axi_rresp}};
  assign s_axi_rlast   = {S_COUNT{m_axi_rlast}};
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Randomized scoreboard bench for axi4_rd_arbiter: requesters, a
// downstream memory model and a round-robin reference.
module tb_axi4_rd_arbiter;

  localparam int S  = 3;
  localparam int IW = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [S*IW-1:0] s_axi_arid;
  logic [S*AW-1:0] s_axi_araddr;
  logic [S*8-1:0]  s_axi_arlen;
  logic [S-1:0]    s_axi_arvalid;
  logic [S-1:0]    s_axi_arready;
  logic [S*IW-1:0] s_axi_rid;
  logic [S*DW-1:0] s_axi_rdata;
  logic [S*2-1:0]  s_axi_rresp;
  logic [S-1:0]    s_axi_rlast;
  logic [S-1:0]    s_axi_rvalid;
  logic [S-1:0]    s_axi_rready;
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IW-1:0]   m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;

  axi4_rd_arbiter #(
    .S_COUNT(S), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .m_axi_arid(m_axi_arid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    int          port;
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  ar_t          exp_ar[$];
  beat_t        exp_b[$];
  logic [S-1:0] exp_rdy[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic        pend[S];
  logic [7:0]  rq_id[S];
  logic [31:0] rq_addr[S];
  logic [7:0]  rq_len[S];
  logic        hs_up[S];

  logic        sl_busy;
  logic [7:0]  sl_id;
  logic [31:0] sl_addr;
  logic [7:0]  sl_len;
  int          sl_beat;
  logic        hs_m_ar, hs_m_r;
  logic [7:0]  cap_id, cap_len;
  logic [31:0] cap_addr;

  bit model_busy;
  int model_g, model_lg, beats_left, beats_tot;

  bit gen_on = 1'b0;
  bit fast   = 1'b0;
  int rst_cnt = 3;
  int n_resets = 0;

  function automatic logic [31:0] fdata(input logic [31:0] a, input int b);
    return a ^ (32'h9e37_79b9 * 32'(b + 1));
  endfunction

  task automatic chk(input string nm, input bit ok,
                     input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic new_req(input int i);
    pend[i]    = 1'b1;
    rq_id[i]   = 8'($urandom);
    rq_addr[i] = $urandom & 32'hffff_fffc;
    if (fast) rq_len[i] = 8'd0;
    else if ($urandom_range(0, 3) == 0) rq_len[i] = 8'd0;
    else rq_len[i] = 8'($urandom_range(1, 5));
  endtask

  task automatic cycle();
    int w;
    @(negedge clk);
    for (int i = 0; i < S; i++) if (hs_up[i]) pend[i] = 1'b0;
    if (hs_m_r) begin
      if (sl_beat == int'(sl_len)) sl_busy = 1'b0;
      sl_beat++;
    end
    if (hs_m_ar) begin
      sl_busy = 1'b1;
      sl_id   = cap_id;
      sl_addr = cap_addr;
      sl_len  = cap_len;
      sl_beat = 0;
    end
    if (rst_cnt > 0) begin
      rst_cnt--;
      rst = 1'b1;
      model_busy = 1'b0;
      model_lg   = S - 1;
      exp_ar.delete();
      exp_b.delete();
      sl_busy = 1'b0;
      for (int i = 0; i < S; i++) if (!pend[i]) new_req(i);
    end else begin
      rst = 1'b0;
    end
    if (!sl_busy) m_axi_rvalid = 1'b0;
    else if (!m_axi_rvalid || hs_m_r)
      m_axi_rvalid = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    m_axi_rid   = sl_id;
    m_axi_rdata = fdata(sl_addr, sl_beat);
    m_axi_rresp = 2'(sl_beat);
    m_axi_rlast = (sl_beat == int'(sl_len));
    m_axi_arready = fast ? 1'b1 : ($urandom_range(0, 2) == 0);
    for (int i = 0; i < S; i++) begin
      if (gen_on && !pend[i] && !rst) begin
        if (fast ? (i == 1) : ($urandom_range(0, 3) == 0)) new_req(i);
      end
      s_axi_arvalid[i]          = pend[i];
      s_axi_arid[i*IW +: IW]    = rq_id[i];
      s_axi_araddr[i*AW +: AW]  = rq_addr[i];
      s_axi_arlen[i*8 +: 8]     = rq_len[i];
      s_axi_rready[i] = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    #1;
    for (int i = 0; i < S; i++)
      hs_up[i] = s_axi_arvalid[i] && s_axi_arready[i];
    hs_m_ar  = !rst && m_axi_arvalid && m_axi_arready;
    hs_m_r   = !rst && m_axi_rvalid && m_axi_rready;
    cap_id   = m_axi_arid;
    cap_addr = m_axi_araddr;
    cap_len  = m_axi_arlen;
    // reference: round robin over pending requests, one burst at a time
    w = -1;
    if (!rst && !model_busy) begin
      for (int k = 1; k <= S; k++) begin
        int p;
        p = (model_lg + k) % S;
        if (w < 0 && pend[p]) w = p;
      end
    end
    if (w >= 0) begin
      exp_rdy.push_back(S'(1) << w);
      exp_ar.push_back('{rq_id[w], rq_addr[w], rq_len[w]});
      for (int b = 0; b <= int'(rq_len[w]); b++)
        exp_b.push_back('{w, rq_id[w], fdata(rq_addr[w], b), 2'(b),
                          b == int'(rq_len[w])});
      model_busy = 1'b1;
      model_g    = w;
      beats_tot  = int'(rq_len[w]) + 1;
      beats_left = beats_tot;
    end else begin
      exp_rdy.push_back('0);
      if (!rst && model_busy &&
          s_axi_rvalid[model_g] && s_axi_rready[model_g]) begin
        beats_left--;
        if (beats_left == 0) begin
          model_busy = 1'b0;
          model_lg   = model_g;
        end
      end
    end
  endtask

  // monitor: compares DUT outputs against the scoreboard queues
  initial begin
    logic [S-1:0] er;
    bit           prev_rst = 1'b1;
    bit           prev_hold = 1'b0;
    logic [7:0]   p_id, p_len;
    logic [31:0]  p_addr;
    int           cyc = 0;
    int           last_g = -1;
    ar_t          a;
    beat_t        b;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (exp_rdy.size() > 0) begin
        er = exp_rdy.pop_front();
        chk("arready", s_axi_arready == er, 64'(s_axi_arready), 64'(er));
      end
      if (rst) begin
        chk("rst_rvalid", s_axi_rvalid == '0, 64'(s_axi_rvalid), 0);
        chk("rst_rready", m_axi_rready == 1'b0, 64'(m_axi_rready), 0);
      end else begin
        if (prev_rst) begin
          chk("rst_arvalid", m_axi_arvalid == 1'b0, 64'(m_axi_arvalid), 0);
          chk("rst_arfields", {m_axi_arid, m_axi_arlen, m_axi_araddr} == '0,
              {m_axi_arid, m_axi_arlen, m_axi_araddr}, 0);
        end
        if (prev_hold)
          chk("ar_hold", m_axi_arvalid && m_axi_arid == p_id &&
              m_axi_araddr == p_addr && m_axi_arlen == p_len,
              {m_axi_arvalid, m_axi_arid, m_axi_araddr},
              {1'b1, p_id, p_addr});
        if (m_axi_arvalid && m_axi_arready) begin
          if (exp_ar.size() == 0) begin
            chk("ar_unexpected", 1'b0, 64'(m_axi_araddr), 0);
          end else begin
            a = exp_ar.pop_front();
            chk("ar_fields", m_axi_arid == a.id && m_axi_araddr == a.addr &&
                m_axi_arlen == a.len, {m_axi_arid, m_axi_arlen, m_axi_araddr},
                {a.id, a.len, a.addr});
          end
        end
        if (s_axi_rvalid != '0)
          chk("rvalid_onehot", $countones(s_axi_rvalid) == 1,
              64'(s_axi_rvalid), 1);
        for (int i = 0; i < S; i++) begin
          if (s_axi_rvalid[i] && s_axi_rready[i]) begin
            if (exp_b.size() == 0) begin
              chk("beat_unexpected", 1'b0, 64'(i), 0);
            end else begin
              b = exp_b.pop_front();
              chk("beat_port", i == b.port, 64'(i), 64'(b.port));
              chk("beat_payload",
                  s_axi_rid[i*IW +: IW] == b.id &&
                  s_axi_rdata[i*DW +: DW] == b.data &&
                  s_axi_rresp[i*2 +: 2] == b.resp &&
                  s_axi_rlast[i] == b.last,
                  {s_axi_rid[i*IW +: IW], s_axi_rresp[i*2 +: 2],
                   s_axi_rlast[i], s_axi_rdata[i*DW +: DW]},
                  {b.id, b.resp, b.last, b.data});
            end
          end
        end
        if (!fast) last_g = -1;
        else if (s_axi_arready != '0) begin
          if (last_g >= 0)
            chk("b2b_gap", cyc - last_g == 3, 64'(cyc - last_g), 3);
          last_g = cyc;
        end
      end
      prev_rst  = rst;
      prev_hold = !rst && m_axi_arvalid && !m_axi_arready;
      p_id      = m_axi_arid;
      p_addr    = m_axi_araddr;
      p_len     = m_axi_arlen;
    end
  end

  task automatic drain(input string nm);
    bit idle;
    int n;
    gen_on = 1'b0;
    idle = 1'b0;
    n = 0;
    while (!idle && n < 500) begin
      cycle();
      n++;
      idle = !model_busy && !sl_busy && exp_ar.size() == 0 &&
             exp_b.size() == 0;
      for (int i = 0; i < S; i++) if (pend[i]) idle = 1'b0;
    end
    chk(nm, idle, 64'(exp_b.size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arvalid = '0; s_axi_rready = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rid = '0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    hs_m_ar = 1'b0; hs_m_r = 1'b0;
    sl_busy = 1'b0; sl_id = '0; sl_addr = '0; sl_len = '0; sl_beat = 0;
    cap_id = '0; cap_addr = '0; cap_len = '0;
    model_busy = 1'b0; model_g = 0; model_lg = S - 1;
    beats_left = 0; beats_tot = 0;
    for (int i = 0; i < S; i++) begin
      pend[i] = 1'b0; hs_up[i] = 1'b0;
      rq_id[i] = '0; rq_addr[i] = '0; rq_len[i] = '0;
    end
    gen_on = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (rst_cnt == 0 && model_busy && beats_left < beats_tot &&
          n_resets < 4 && $urandom_range(0, 30) == 0) begin
        rst_cnt = 1;
        n_resets++;
      end
      cycle();
    end
    drain("drain_random");
    fast = 1'b1;
    gen_on = 1'b1;
    repeat (40) cycle();
    drain("drain_fast");
    fast = 1'b0;
    repeat (3) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
